core_data_mem_responder: RTL and testbench

//  Data-memory responder: the memory side of the execution unit's load/store port.

---
 rtl/core_data_mem_responder_if.sv | 26 ++
 rtl/core_data_mem_responder.sv | 134 +++++++++++++
 tb/tb_core_data_mem_responder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_data_mem_responder_if.sv
// Load/store port between the execution unit (master) and the data-memory responder (slave).
interface core_data_mem_responder_if #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic                      req_we_i;
  logic [1:0]                req_size_i;
  logic [MEM_ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0]     req_wdata_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [DATA_WIDTH-1:0]     rsp_rdata_o;
  logic                      rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/core_data_mem_responder.sv
// Data-memory responder: one request at a time, optional wait states, byte-lane
// masked stores and right-justified zero-filled loads on an internal word RAM.
module core_data_mem_responder #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int WAIT_STATES    = 0
) (
  input logic clk_i,
  input logic rst_i,
  core_data_mem_responder_if.slave bus
);
  localparam int WORD_AW = MEM_ADDR_WIDTH - 2;
  localparam int DEPTH   = 1 << WORD_AW;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                    state;
  logic [3:0]                cnt;
  logic                      we_q;
  logic                      err_q;
  logic [1:0]                size_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      rsp_valid;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_err;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  logic [WORD_AW-1:0]        idx;
  logic [1:0]                lane;
  logic                      access;
  logic [3:0]                strb;
  logic [DATA_WIDTH-1:0]     wword;
  logic [DATA_WIDTH-1:0]     rword;
  logic [DATA_WIDTH-1:0]     rfmt;

  assign idx    = addr_q[MEM_ADDR_WIDTH-1:2];
  assign lane   = addr_q[1:0];
  assign access = (state == BUSY) && (cnt == 4'd0);

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  // Store data is replicated across lanes so the strobe alone selects the target bytes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    strb  = 4'b0000;
    wword = '0;
    rword = mem[idx] >> {lane, 3'b000};
    rfmt  = '0;
    case (size_q)
      2'b00: begin
        strb  = 4'b0001 << lane;
        wword = {4{wdata_q[7:0]}};
        rfmt  = DATA_WIDTH'(rword[7:0]);
      end
      2'b01: begin
        strb  = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
        rfmt  = DATA_WIDTH'(rword[15:0]);
      end
      2'b10: begin
        strb  = 4'b1111;
        wword = wdata_q;
        rfmt  = rword;
      end
      default: ;
    endcase
  end

  // NOTE: RAM contents are deliberately not reset; the write is gated by rst_i so a store
  // whose access edge coincides with reset is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && access && we_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[idx][b*8 +: 8] <= wword[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            we_q    <= bus.req_we_i;
            size_q  <= bus.req_size_i;
            addr_q  <= bus.req_addr_i;
            wdata_q <= bus.req_wdata_i;
            err_q   <= misaligned(bus.req_size_i, bus.req_addr_i[1:0]);
            cnt     <= 4'(WAIT_STATES);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_rdata <= (err_q || we_q) ? '0 : rfmt;
            rsp_err   <= err_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = (state == IDLE) && !rst_i;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_rdata_o = rsp_rdata;
  assign bus.rsp_err_o   = rsp_err;
endmodule

// File: tb/tb_core_data_mem_responder.sv
// Bench for core_data_mem_responder: two instances (0 and 3 wait states) against a byte-array model.
module tb_core_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] bytes [2][1024];

  always #5 clk = ~clk;

  core_data_mem_responder_if #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32)) bus0 ();
  core_data_mem_responder_if #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32)) bus1 ();

  assign bus0.req_valid_i = req_valid & ~sel;
  assign bus1.req_valid_i = req_valid & sel;
  assign bus0.req_we_i    = req_we;
  assign bus1.req_we_i    = req_we;
  assign bus0.req_size_i  = req_size;
  assign bus1.req_size_i  = req_size;
  assign bus0.req_addr_i  = req_addr;
  assign bus1.req_addr_i  = req_addr;
  assign bus0.req_wdata_i = req_wdata;
  assign bus1.req_wdata_i = req_wdata;
  assign bus0.rsp_ready_i = rsp_ready;
  assign bus1.rsp_ready_i = rsp_ready;

  assign req_ready = sel ? bus1.req_ready_o : bus0.req_ready_o;
  assign rsp_valid = sel ? bus1.rsp_valid_o : bus0.rsp_valid_o;
  assign rsp_rdata = sel ? bus1.rsp_rdata_o : bus0.rsp_rdata_o;
  assign rsp_err   = sel ? bus1.rsp_err_o   : bus0.rsp_err_o;

  core_data_mem_responder #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(0))
    dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  core_data_mem_responder #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(3))
    dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Memory viewed as a flat byte array; alignment is simply addr divisible by access size.
  function automatic void model_access(input int s, input bit we, input logic [1:0] size,
                                       input logic [9:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rd, output bit er);
    int nb;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    rd = '0;
    er = (size == 2'd3) || ((int'(addr) % nb) != 0);
    if (er) return;
    for (int i = 0; i < nb; i++) begin
      if (we) bytes[s][int'(addr) + i] = wdata[8*i +: 8];
      else    rd[8*i +: 8] = bytes[s][int'(addr) + i];
    end
  endfunction

  // Called at a negedge; returns at a negedge with rsp_ready low.
  task automatic txn(input string name, input bit we, input logic [1:0] size,
                     input logic [9:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input bit exp_er,
                     input int hold, input bit noisy);
    int t;
    int n;
    int ws;
    ws = sel ? 3 : 0;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check({name, "_ready_timeout"}, 32'd0, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = noisy;
    n = 1;
    while (!rsp_valid && n < 40) begin
      if (noisy) begin
        req_we    = $urandom_range(0, 1);
        req_size  = 2'($urandom_range(0, 3));
        req_addr  = 10'($urandom);
        req_wdata = $urandom;
      end
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    check({name, "_latency"}, 32'(n), 32'(2 + ws));
    for (int h = 0; h < hold; h++) begin
      check({name, "_hold_rdata"}, rsp_rdata, exp_rd);
      check({name, "_hold_err"}, 32'(rsp_err), 32'(exp_er));
      check({name, "_hold_ready"}, 32'(req_ready), 32'd0);
      check({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check({name, "_rdata"}, rsp_rdata, exp_rd);
    check({name, "_err"}, 32'(rsp_err), 32'(exp_er));
    @(negedge clk);
    check({name, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
  endtask

  task automatic mtxn(input string name, input bit we, input logic [1:0] size,
                      input logic [9:0] addr, input logic [31:0] wdata,
                      input int hold, input bit noisy);
    logic [31:0] rd;
    bit er;
    model_access(int'(sel), we, size, addr, wdata, rd, er);
    txn(name, we, size, addr, wdata, rd, er, hold, noisy);
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  size;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_er;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] drd;
    bit der;
    int k;
    bit bad;

    vecs[0]  = '{1'b1, 2'd2, 10'h010, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'd2, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'd2, 10'h010, 32'h11223344, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 2'd0, 10'h013, 32'h000000AA, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 2'd2, 10'h010, 32'h0,        32'hAA223344, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 10'h013, 32'h0,        32'h000000AA, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 10'h012, 32'h0,        32'h0000AA22, 1'b0};
    vecs[7]  = '{1'b0, 2'd1, 10'h011, 32'h0,        32'h0,        1'b1};
    vecs[8]  = '{1'b1, 2'd2, 10'h012, 32'h55667788, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 2'd2, 10'h010, 32'h0,        32'hAA223344, 1'b0};
    vecs[10] = '{1'b0, 2'd3, 10'h010, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b1, 2'd2, 10'h014, 32'h00000000, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 2'd1, 10'h016, 32'h1234CAFE, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 2'd2, 10'h014, 32'h0,        32'hCAFE0000, 1'b0};
    vecs[14] = '{1'b0, 2'd1, 10'h016, 32'h0,        32'h0000CAFE, 1'b0};
    vecs[15] = '{1'b0, 2'd0, 10'h011, 32'h0,        32'h00000033, 1'b0};

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_ready",  32'(req_ready), 32'd0);
      check("rst_valid",  32'(rsp_valid), 32'd0);
      check("rst_rdata",  rsp_rdata,      32'd0);
      check("rst_err",    32'(rsp_err),   32'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      model_access(0, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, drd, der);
      txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
          vecs[i].exp_rd, vecs[i].exp_er, 0, 1'b0);
    end

    // Back-to-back: valid held high; fields change during BUSY, second accepted only in IDLE.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 10'h030; req_wdata = 32'hA5A5_0001;
    rsp_ready = 1'b1;
    @(posedge clk);
    model_access(0, 1'b1, 2'd2, 10'h030, 32'hA5A5_0001, drd, der);
    @(negedge clk);
    req_addr = 10'h034; req_wdata = 32'h5A5A_0002;
    k = 1;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("b2b_spacing", 32'(k), 32'd3);
    @(posedge clk);
    model_access(0, 1'b1, 2'd2, 10'h034, 32'h5A5A_0002, drd, der);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("b2b_second_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    txn("b2b_rd0", 1'b0, 2'd2, 10'h030, 32'h0, 32'hA5A5_0001, 1'b0, 0, 1'b0);
    txn("b2b_rd1", 1'b0, 2'd2, 10'h034, 32'h0, 32'h5A5A_0002, 1'b0, 0, 1'b0);

    // Three wait states: latency, response hold, noisy inputs during BUSY.
    sel = 1'b1;
    @(negedge clk);
    mtxn("ws3_sw",   1'b1, 2'd2, 10'h040, 32'h12345678, 0, 1'b0);
    txn("ws3_hold",  1'b0, 2'd2, 10'h040, 32'h0, 32'h12345678, 1'b0, 4, 1'b0);
    mtxn("ws3_noisy_sw", 1'b1, 2'd2, 10'h044, 32'hFEEDF00D, 0, 1'b1);
    txn("ws3_noisy_rd", 1'b0, 2'd2, 10'h044, 32'h0, 32'hFEEDF00D, 1'b0, 0, 1'b0);

    // Reset during BUSY with cnt=2: store dropped, no response.
    mtxn("rst_pre_sw", 1'b1, 2'd2, 10'h020, 32'h0BADF00D, 0, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 10'h020; req_wdata = 32'hFFFFFFFF;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready_low", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", 32'(req_ready), 32'd1);
    bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) bad = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_rsp", 32'(bad), 32'd0);
    rsp_ready = 1'b0;
    txn("midrst_rd", 1'b0, 2'd2, 10'h020, 32'h0, 32'h0BADF00D, 1'b0, 0, 1'b0);

    // Randomized traffic on both instances against the byte-array model.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(negedge clk);
      for (int w = 0; w < 16; w++)
        mtxn("rnd_init", 1'b1, 2'd2, 10'(10'h100 + 4 * w), $urandom, 0, 1'b0);
      for (int r = 0; r < 40; r++)
        mtxn($sformatf("rnd%0d_%0d", s, r), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             10'(10'h100 + $urandom_range(0, 63)), $urandom, $urandom_range(0, 2),
             1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
